// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Boot-time program loader. Consumes a byte stream made of a
//             4-byte little-endian word count N followed by N little-endian
//             32-bit words, and writes each word into instruction RAM at
//             ADDR_BASE+k. Keeps the CPU stalled until the whole program is
//             in place. Oversized programs are rejected without any write.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             in_valid/in_data  - byte source (transfer on valid && ready)
//             in_ready          - loader accepting bytes (LEN/DATA only)
//             mem_addr/mem_din  - word address / data to instruction RAM
//             mem_we            - single-cycle write strobe
//             done              - program fully written
//             err               - declared length exceeded DEPTH_WORDS
//             cpu_hold          - stall CPU fetch while high (= ~done)
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BASE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);
  localparam logic [29:0] C_BASE  = 30'(ADDR_BASE);

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;     // first three bytes of the current group
  logic [31:0] r_len;
  logic [31:0] r_k;
  logic [29:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_mem_we;

  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_word;

  assign w_ready  = (r_state == S_LEN) || (r_state == S_DATA);
  assign w_accept = in_valid && w_ready;
  // Bytes arrive LSB first: the newest byte is always the top byte of the word.
  assign w_word   = {in_data, r_shift};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_len      <= 32'd0;
      r_k        <= 32'd0;
      r_mem_addr <= 30'd0;
      r_mem_din  <= 32'd0;
      r_mem_we   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {in_data, r_shift[23:8]};
        if (r_byte_cnt == 2'd3) begin
          case (r_state)
            S_LEN: begin
              r_len <= w_word;
              r_k   <= 32'd0;
              if (w_word == 32'd0) begin
                r_state <= S_DONE;
              end else if (w_word > C_DEPTH) begin
                r_state <= S_ERR;
              end else begin
                r_state <= S_DATA;
              end
            end
            S_DATA: begin
              r_mem_din  <= w_word;
              r_mem_addr <= C_BASE + r_k[29:0];
              r_mem_we   <= 1'b1;
              r_k        <= r_k + 32'd1;
              // Leaving on the final word's edge makes done coincide with
              // the last write strobe.
              if (r_k == r_len - 32'd1) begin
                r_state <= S_DONE;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Gated by rst so the source sees no readiness while reset is held.
  assign in_ready = w_ready && !rst;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);
  assign cpu_hold = (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader. Instance 0 uses
//             default parameters, instance 1 uses ADDR_BASE = 0x100.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        in_valid0, in_valid1;
  logic [7:0]  in_data0, in_data1;
  logic        in_ready0, in_ready1;
  logic [29:0] mem_addr0, mem_addr1;
  logic [31:0] mem_din0, mem_din1;
  logic        mem_we0, mem_we1;
  logic        done0, done1;
  logic        err0, err1;
  logic        cpu_hold0, cpu_hold1;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .mem_addr(mem_addr0), .mem_din(mem_din0),
    .mem_we(mem_we0), .done(done0), .err(err0), .cpu_hold(cpu_hold0)
  );

  prog_loader #(.DEPTH_WORDS(256), .ADDR_BASE('h100)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .mem_addr(mem_addr1), .mem_din(mem_din1),
    .mem_we(mem_we1), .done(done1), .err(err1), .cpu_hold(cpu_hold1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write log captured on the falling edge, away from the active edge.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic        done;
    logic        hold;
  } wr_t;

  wr_t  q0[$];
  wr_t  q1[$];
  int   dbl0 = 0;
  int   dbl1 = 0;
  logic prev_we0 = 1'b0;
  logic prev_we1 = 1'b0;

  always @(negedge clk) begin
    if (mem_we0) q0.push_back('{addr: mem_addr0, data: mem_din0, done: done0, hold: cpu_hold0});
    if (mem_we1) q1.push_back('{addr: mem_addr1, data: mem_din1, done: done1, hold: cpu_hold1});
    if (mem_we0 && prev_we0) dbl0 <= dbl0 + 1;
    if (mem_we1 && prev_we1) dbl1 <= dbl1 + 1;
    prev_we0 <= mem_we0;
    prev_we1 <= mem_we1;
  end

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if (sel == 0) begin in_valid0 = 1'b1; in_data0 = b; end
    else          begin in_valid1 = 1'b1; in_data1 = b; end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int gap);
    send_byte(sel, w[7:0],   gap);
    send_byte(sel, w[15:8],  gap);
    send_byte(sel, w[23:16], gap);
    send_byte(sel, w[31:24], gap);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_data0 = 8'h0; in_data1 = 8'h0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready0); end
    n_checks++; if (mem_we0 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we0); end
    n_checks++; if (mem_addr0 !== 30'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr0); end
    n_checks++; if (mem_din0 !== 32'd0) begin n_fail++; $display("FAIL reset_mem_din: got %h expected 0", mem_din0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done0); end
    n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err0); end
    n_checks++; if (cpu_hold0 !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold0); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready0); end
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = q0.size();
    send_word(0, 32'd2, 0);
    send_word(0, 32'h00100093, 0);
    send_word(0, 32'h00200113, 0);
    settle();
    n_checks++; if (q0.size() !== base + 2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", q0.size() - base); end
    if (q0.size() >= base + 2) begin
      n_checks++; if (q0[base].addr !== 30'd0) begin n_fail++; $display("FAIL basic_addr0: got %h expected 0", q0[base].addr); end
      n_checks++; if (q0[base].data !== 32'h00100093) begin n_fail++; $display("FAIL basic_data0: got %h expected 00100093", q0[base].data); end
      n_checks++; if (q0[base].done !== 1'b0) begin n_fail++; $display("FAIL basic_done_w0: got %b expected 0", q0[base].done); end
      n_checks++; if (q0[base+1].addr !== 30'd1) begin n_fail++; $display("FAIL basic_addr1: got %h expected 1", q0[base+1].addr); end
      n_checks++; if (q0[base+1].data !== 32'h00200113) begin n_fail++; $display("FAIL basic_data1: got %h expected 00200113", q0[base+1].data); end
      n_checks++; if (q0[base+1].done !== 1'b1) begin n_fail++; $display("FAIL basic_done_w1: got %b expected 1", q0[base+1].done); end
      n_checks++; if (q0[base+1].hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold_w1: got %b expected 0", q0[base+1].hold); end
    end
    n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_after: got %b expected 0", in_ready0); end
    n_checks++; if (mem_din0 !== 32'h00200113) begin n_fail++; $display("FAIL basic_din_hold: got %h expected 00200113", mem_din0); end
    n_checks++; if (mem_addr0 !== 30'd1) begin n_fail++; $display("FAIL basic_addr_hold: got %h expected 1", mem_addr0); end
    n_checks++; if (mem_we0 !== 1'b0) begin n_fail++; $display("FAIL basic_we_low: got %b expected 0", mem_we0); end
  endtask

  task automatic test_zero_len();
    int base;
    do_reset();
    base = q0.size();
    send_word(0, 32'd0, 0);
    settle();
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done0); end
    n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %b expected 0", in_ready0); end
    n_checks++; if (cpu_hold0 !== 1'b0) begin n_fail++; $display("FAIL zero_hold: got %b expected 0", cpu_hold0); end
    // Traffic after completion must be ignored.
    send_word(0, 32'h11223344, 0);
    send_word(0, 32'h55667788, 0);
    settle();
    n_checks++; if (q0.size() !== base) begin n_fail++; $display("FAIL zero_no_write: got %0d expected 0", q0.size() - base); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL zero_terminal: got %b expected 1", done0); end
  endtask

  task automatic test_too_long();
    int base;
    do_reset();
    base = q0.size();
    send_word(0, 32'd257, 0);
    send_word(0, 32'hDEADBEEF, 0);
    settle();
    n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL long_err: got %b expected 1", err0); end
    n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL long_ready: got %b expected 0", in_ready0); end
    n_checks++; if (cpu_hold0 !== 1'b1) begin n_fail++; $display("FAIL long_hold: got %b expected 1", cpu_hold0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL long_done: got %b expected 0", done0); end
    n_checks++; if (q0.size() !== base) begin n_fail++; $display("FAIL long_no_write: got %0d expected 0", q0.size() - base); end
  endtask

  task automatic test_max_len();
    int base;
    int bad;
    logic [31:0] exp_w;
    do_reset();
    base = q0.size();
    send_word(0, 32'd256, 0);
    for (int i = 0; i < 256; i++) begin
      exp_w = 32'h5A000000 + 32'(i) * 32'h00010003;
      send_word(0, exp_w, 0);
    end
    settle();
    n_checks++; if (q0.size() !== base + 256) begin n_fail++; $display("FAIL max_count: got %0d expected 256", q0.size() - base); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (base + i < q0.size()) begin
        exp_w = 32'h5A000000 + 32'(i) * 32'h00010003;
        n_checks++;
        if (q0[base+i].addr !== 30'(i) || q0[base+i].data !== exp_w) begin
          n_fail++;
          if (bad < 8) $display("FAIL max_word%0d: got addr %h data %h expected addr %h data %h", i, q0[base+i].addr, q0[base+i].data, 30'(i), exp_w);
          bad++;
        end
      end
    end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL max_done: got %b expected 1", done0); end
    n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL max_err: got %b expected 0", err0); end
  endtask

  task automatic test_gaps();
    int base;
    logic [31:0] w;
    do_reset();
    base = q0.size();
    w = 32'd1;
    for (int i = 0; i < 4; i++) send_byte(0, w[8*i +: 8], int'($urandom_range(1, 5)));
    w = 32'h12345678;
    for (int i = 0; i < 3; i++) send_byte(0, w[8*i +: 8], int'($urandom_range(1, 5)));
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (q0.size() !== base) begin n_fail++; $display("FAIL gaps_early_write: got %0d expected 0", q0.size() - base); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL gaps_early_done: got %b expected 0", done0); end
    send_byte(0, w[31:24], int'($urandom_range(1, 5)));
    settle();
    n_checks++; if (q0.size() !== base + 1) begin n_fail++; $display("FAIL gaps_count: got %0d expected 1", q0.size() - base); end
    if (q0.size() >= base + 1) begin
      n_checks++; if (q0[base].data !== 32'h12345678) begin n_fail++; $display("FAIL gaps_data: got %h expected 12345678", q0[base].data); end
      n_checks++; if (q0[base].addr !== 30'd0) begin n_fail++; $display("FAIL gaps_addr: got %h expected 0", q0[base].addr); end
    end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got %b expected 1", done0); end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    // Reset landing while a write strobe is pending must cancel it.
    send_word(0, 32'd2, 0);
    send_word(0, 32'hAAAA5555, 0);
    n_checks++; if (mem_we0 !== 1'b1) begin n_fail++; $display("FAIL midrst_we_before: got %b expected 1", mem_we0); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we0 !== 1'b0) begin n_fail++; $display("FAIL midrst_we_cancel: got %b expected 0", mem_we0); end
    n_checks++; if (mem_din0 !== 32'd0) begin n_fail++; $display("FAIL midrst_din_clear: got %h expected 0", mem_din0); end
    do_reset();
    // Reset after two bytes of word 1.
    send_word(0, 32'd2, 0);
    send_word(0, 32'h01020304, 0);
    send_byte(0, 8'hEE, 0);
    send_byte(0, 8'hDD, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", in_ready0); end
    n_checks++; if (mem_addr0 !== 30'd0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", mem_addr0); end
    n_checks++; if (cpu_hold0 !== 1'b1) begin n_fail++; $display("FAIL midrst_hold: got %b expected 1", cpu_hold0); end
    n_checks++; if (done0 !== 1'b0 || err0 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got done %b err %b expected 0 0", done0, err0); end
    do_reset();
    base = q0.size();
    send_word(0, 32'd1, 0);
    send_word(0, 32'hCAFEBABE, 0);
    settle();
    n_checks++; if (q0.size() !== base + 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", q0.size() - base); end
    if (q0.size() >= base + 1) begin
      n_checks++; if (q0[base].addr !== 30'd0 || q0[base].data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL midrst_word: got addr %h data %h expected addr 0 data cafebabe", q0[base].addr, q0[base].data); end
    end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL midrst_done: got %b expected 1", done0); end
  endtask

  task automatic test_addr_base();
    int base;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00000013;
    exp_w[1] = 32'hFFF00093;
    exp_w[2] = 32'h0000006F;
    do_reset();
    base = q1.size();
    send_word(1, 32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(1, exp_w[i], 1);
    settle();
    n_checks++; if (q1.size() !== base + 3) begin n_fail++; $display("FAIL base_count: got %0d expected 3", q1.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < q1.size()) begin
        n_checks++;
        if (q1[base+i].addr !== 30'h100 + 30'(i) || q1[base+i].data !== exp_w[i]) begin
          n_fail++;
          $display("FAIL base_word%0d: got addr %h data %h expected addr %h data %h", i, q1[base+i].addr, q1[base+i].data, 30'h100 + 30'(i), exp_w[i]);
        end
      end
    end
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL base_done: got %b expected 1", done1); end
  endtask

  task automatic test_strobe_width();
    n_checks++; if (dbl0 !== 0) begin n_fail++; $display("FAIL strobe_width0: got %0d doubles expected 0", dbl0); end
    n_checks++; if (dbl1 !== 0) begin n_fail++; $display("FAIL strobe_width1: got %0d doubles expected 0", dbl1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_max_len();
    test_gaps();
    test_mid_reset();
    test_addr_base();
    test_strobe_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
- REQ-001: Parameter DEPTH_WORDS, default 256: instruction RAM capacity in 32-bit words; largest accepted program length.
- REQ-002: Parameter ADDR_BASE, default 0: word address written for program word 0.
- REQ-003: clk  input  1  single clock; all state changes on rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  byte source presents in_data.
- REQ-006: in_data  input  8  program stream byte.
- REQ-007: in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready at the rising edge.
- REQ-008: mem_addr  output  30  word address to instruction RAM, same word-address form as the CPU fetch port (byte address [31:2]).
- REQ-009: mem_din  output  32  word to write.
- REQ-010: mem_we  output  1  one-cycle write strobe.
- REQ-011: done  output  1  program fully written.
- REQ-012: err  output  1  declared length exceeded DEPTH_WORDS.
- REQ-013: cpu_hold  output  1  holds CPU fetch/PC stalled while high.

Function
- REQ-014: Stream format SHALL be a 4-byte little-endian word count N, then N words, each as 4 bytes little-endian (byte 0 = bits [7:0]).
- REQ-015: States SHALL be LEN, DATA, DONE, ERR; reset enters LEN.
- REQ-016: in_ready SHALL be 1 in LEN and DATA, 0 in DONE and ERR; it is independent of in_valid.
- REQ-017: A 2-bit byte counter SHALL count accepted bytes within the current 4-byte group and wrap 3->0.
- REQ-018: LEN: on the 4th accepted byte, if N==0 go to DONE; if N>DEPTH_WORDS go to ERR; otherwise go to DATA with word index k=0.
- REQ-019: DATA: on the edge accepting the 4th byte of word k, mem_din SHALL load the assembled word, mem_addr SHALL load ADDR_BASE+k, and mem_we SHALL be 1 for exactly the following cycle.
- REQ-020: mem_addr and mem_din SHALL hold their values until the next write; mem_we SHALL never be high for two consecutive cycles.
- REQ-021: k SHALL increment after each word write; when word N-1 is accepted, state SHALL go to DONE on the same edge, so done rises in the same cycle as the final mem_we.
- REQ-022: Bytes not accompanied by in_valid SHALL not advance any counter; gaps of any length are allowed mid-word.
- REQ-023: cpu_hold SHALL equal NOT done; it stays 1 in ERR.
- REQ-024: DONE and ERR SHALL be terminal until rst; in_valid in those states has no effect.
- REQ-025: err SHALL be 1 only in ERR; no mem_we is issued for a rejected program.
- REQ-026: N and k SHALL be 32-bit compares; N==DEPTH_WORDS is accepted.

Reset
- REQ-027: While rst is high: state=LEN, counters=0, in_ready=0, mem_we=0, mem_addr=0, mem_din=0, done=0, err=0, cpu_hold=1.
- REQ-028: in_ready SHALL rise in the first cycle after rst deasserts.
- REQ-029: rst asserted mid-word or mid-program SHALL discard partial data immediately; a pending mem_we SHALL be cancelled; the next stream restarts at a length field.

Verification
- REQ-030: Bytes 02 00 00 00, 93 00 10 00, 13 01 20 00, continuous valid -> mem_we pulses at word addrs 0 and 1 with 0x00100093 and 0x00200113; done=1 and cpu_hold=0 with the second pulse.
- REQ-031: N=0 (00 00 00 00) -> DONE after the 4th byte, no mem_we, in_ready=0.
- REQ-032: N=257 with DEPTH_WORDS=256 -> err=1, in_ready=0, no writes; N=256 -> 256 writes to addrs 0..255, done=1.
- REQ-033: N=1 with random in_valid gaps between every byte -> single write of the correct word; no pulse before the 4th byte.
- REQ-034: rst pulse after 2 data bytes of word 1 -> outputs at reset values; a fresh stream of N=1 then writes addr 0 correctly.
- REQ-035: ADDR_BASE=0x100, N=3 -> writes to 0x100, 0x101, 0x102 in order.
